// File: rtl/pipe_pkg.sv
// Shared constants and types for the EX-stage multiply/divide unit.
package pipe_pkg;

  localparam int WIDTH = 32;
  localparam int STEPS = WIDTH;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // Two's-complement magnitude of v when neg is set, otherwise v unchanged.
  function automatic logic [WIDTH-1:0] abs_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/pipe_exe_muldiv_if.sv
// EX-stage to multiply/divide unit interface: instruction side plus HI/LO results.
interface pipe_exe_muldiv_if;
  import pipe_pkg::*;

  logic             start;
  logic             ebubble;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] eb;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, ebubble, flush, op, ea, eb, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, ebubble, flush, op, ea, eb, mthi, mtlo,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/pipe_exe_muldiv.sv
// Iterative 32-step shift-add multiplier / restoring divider owning HI/LO.
// Signed operations run on magnitudes; the sign is restored in the FIX state.
module pipe_exe_muldiv
  import pipe_pkg::*;
(
  input logic              clock,
  input logic              reset,
  pipe_exe_muldiv_if.slave mdu
);

  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  mdu_state_e         state, state_next;
  logic               div_op;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc, qr, mcand, ea_orig, hi_r, lo_r;
  logic               neg_res, neg_rem, div0, done_r;
  logic               accept, move_ok, is_signed, sign_a, sign_b;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

  assign accept    = mdu.start & ~mdu.ebubble & ~mdu.flush & (state == IDLE);
  assign move_ok   = (state == IDLE) & ~mdu.ebubble & ~mdu.start & ~mdu.flush;
  assign is_signed = ~mdu.op[0];
  assign sign_a    = is_signed & mdu.ea[WIDTH-1];
  assign sign_b    = is_signed & mdu.eb[WIDTH-1];

  assign mdu.busy = (state != IDLE);
  assign mdu.done = done_r;
  assign mdu.hi   = hi_r;
  assign mdu.lo   = lo_r;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: flush always returns to IDLE, otherwise accept/count/fix sequence.
  always_comb begin
    state_next = state;
    if (mdu.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = CALC;
        CALC:    if (cnt == LAST) state_next = FIX;
        FIX:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // One iteration step: multiply add-and-shift sum, divide shifted partial remainder.
  always_comb begin
    mul_sum = {1'b0, acc} + {1'b0, (qr[0] ? mcand : {WIDTH{1'b0}})};
    div_sh  = {acc, qr[WIDTH-1]};
  end

  // Sign correction and result selection applied on the FIX edge.
  always_comb begin
    prod = {acc, qr};
    if (neg_res) prod = -prod;
    quot   = neg_res ? -qr : qr;
    rem    = neg_rem ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (div_op) begin
      if (div0) begin
        res_hi = ea_orig;
        res_lo = {WIDTH{1'b1}};
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
  end

  // Datapath: operand latch, iteration, HI/LO write-back and mthi/mtlo moves.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_op  <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      qr      <= '0;
      mcand   <= '0;
      ea_orig <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        div_op  <= mdu.op[1];
        cnt     <= '0;
        acc     <= '0;
        neg_res <= sign_a ^ sign_b;
        neg_rem <= sign_a;
        div0    <= (mdu.eb == '0);
        ea_orig <= mdu.ea;
        if (mdu.op[1]) begin
          qr    <= abs_if(sign_a, mdu.ea);
          mcand <= abs_if(sign_b, mdu.eb);
        end else begin
          mcand <= abs_if(sign_a, mdu.ea);
          qr    <= abs_if(sign_b, mdu.eb);
        end
      end else if (state == CALC) begin
        cnt <= cnt + CNT_W'(1);
        if (div_op) begin
          if (div_sh >= {1'b0, mcand}) begin
            acc <= div_sh[WIDTH-1:0] - mcand;
            qr  <= {qr[WIDTH-2:0], 1'b1};
          end else begin
            acc <= div_sh[WIDTH-1:0];
            qr  <= {qr[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc <= mul_sum[WIDTH:1];
          qr  <= {mul_sum[0], qr[WIDTH-1:1]};
        end
      end else if (state == FIX && !mdu.flush) begin
        hi_r   <= res_hi;
        lo_r   <= res_lo;
        done_r <= 1'b1;
      end else if (move_ok) begin
        if (mdu.mthi) hi_r <= mdu.ea;
        if (mdu.mtlo) lo_r <= mdu.ea;
      end
    end
  end

endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// Self-checking bench for pipe_exe_muldiv: randomized ops against an arithmetic
// reference model through a scoreboard, plus directed flush/reset/move cases.
module tb_pipe_exe_muldiv;
  import pipe_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pipe_exe_muldiv_if mdu();

  pipe_exe_muldiv dut (
    .clock (clock),
    .reset (reset),
    .mdu   (mdu)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        scoreboard[$];
  exp_t        mon_e;
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic [31:0] model_hi   = '0;
  logic [31:0] model_lo   = '0;

  // Cycle counter used for latency checks.
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, req);
    end
  endfunction

  // Expected HI/LO from plain integer arithmetic.
  function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, q, r;
    logic [63:0] p;
    sa  = $signed(a);
    sbv = $signed(b);
    e   = '0;
    case (op)
      OP_MULT: begin
        p = sa * sbv;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      OP_DIV: begin
        if (b == 0) begin
          e.hi = a;
          e.lo = 32'hFFFFFFFF;
        end else begin
          q = sa / sbv;
          r = sa % sbv;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          e.hi = a;
          e.lo = 32'hFFFFFFFF;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse pops one expected result.
  always @(negedge clock) begin
    if (!reset && mdu.done) begin
      check_output("done_with_busy", {63'd0, mdu.busy}, 64'd0);
      if (scoreboard.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, want no pulse", cyc);
      end else begin
        mon_e = scoreboard.pop_front();
        check_output("latency", 64'(cyc), 64'(mon_e.due));
        check_output("hi", {32'd0, mdu.hi}, {32'd0, mon_e.hi});
        check_output("lo", {32'd0, mdu.lo}, {32'd0, mon_e.lo});
        model_hi = mon_e.hi;
        model_lo = mon_e.lo;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    mdu.start   = 1'b0;
    mdu.ebubble = 1'b0;
    mdu.flush   = 1'b0;
    mdu.mthi    = 1'b0;
    mdu.mtlo    = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mdu.busy && n < 200) begin
      step();
      n++;
    end
    if (mdu.busy) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idle_timeout: got busy=1 after %0d cycles, want 0", n);
    end
    step();
    step();
  endtask

  // Issue one operation, expect it to be accepted and scored later.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    mdu.op    = op;
    mdu.ea    = a;
    mdu.eb    = b;
    mdu.start = 1'b1;
    step();
    mdu.start = 1'b0;
    check_output("accept_busy", {63'd0, mdu.busy}, 64'd1);
    e     = ref_model(op, a, b);
    e.due = cyc + 33;
    scoreboard.push_back(e);
    mdu.ea = $urandom;
    mdu.eb = $urandom;
  endtask

  // Global watchdog.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    logic [31:0] h, l, a, b;
    logic [1:0]  op;
    int          sel;

    clear_inputs();
    mdu.op = OP_MULT;
    mdu.ea = '0;
    mdu.eb = '0;
    reset  = 1'b1;
    step();
    step();
    step();
    check_output("reset_busy", {63'd0, mdu.busy}, 64'd0);
    check_output("reset_done", {63'd0, mdu.done}, 64'd0);
    check_output("reset_hi", {32'd0, mdu.hi}, 64'd0);
    check_output("reset_lo", {32'd0, mdu.lo}, 64'd0);
    reset = 1'b0;
    step();

    // multu max*max with busy length
    apply_stimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n = 0;
    while (mdu.busy && n < 100) begin
      n++;
      step();
    end
    check_output("busy_len", 64'(n), 64'd33);

    // signed multiply/divide, divide by zero, signed overflow
    apply_stimulus(OP_MULT, 32'hFFFFFFF9, 32'd3);
    apply_stimulus(OP_DIV, 32'hFFFFFFF9, 32'd2);
    apply_stimulus(OP_DIVU, 32'd100, 32'd0);
    apply_stimulus(OP_DIV, 32'd100, 32'd0);
    apply_stimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF);

    // flush mid-operation: no done, HI/LO unchanged
    wait_idle();
    h = model_hi;
    l = model_lo;
    mdu.op = OP_DIVU;
    mdu.ea = 32'd100;
    mdu.eb = 32'd7;
    mdu.start = 1'b1;
    step();
    mdu.start = 1'b0;
    repeat (9) step();
    mdu.flush = 1'b1;
    step();
    mdu.flush = 1'b0;
    check_output("flush_busy", {63'd0, mdu.busy}, 64'd0);
    check_output("flush_done", {63'd0, mdu.done}, 64'd0);
    repeat (40) step();
    check_output("flush_hi", {32'd0, mdu.hi}, {32'd0, h});
    check_output("flush_lo", {32'd0, mdu.lo}, {32'd0, l});

    // flush together with start: nothing accepted
    mdu.start = 1'b1;
    mdu.flush = 1'b1;
    step();
    clear_inputs();
    check_output("flush_start_busy", {63'd0, mdu.busy}, 64'd0);

    // mthi while idle
    mdu.ea   = 32'h12345678;
    mdu.mthi = 1'b1;
    step();
    mdu.mthi = 1'b0;
    check_output("mthi", {32'd0, mdu.hi}, 64'h12345678);
    model_hi = 32'h12345678;

    // mtlo during busy is ignored
    apply_stimulus(OP_DIVU, 32'd1000, 32'd9);
    mdu.ea   = 32'hDEADBEEF;
    mdu.mtlo = 1'b1;
    step();
    mdu.mtlo = 1'b0;
    check_output("mtlo_busy", {32'd0, mdu.lo}, {32'd0, model_lo});

    // start with ebubble: no accept
    wait_idle();
    mdu.ebubble = 1'b1;
    mdu.start   = 1'b1;
    step();
    clear_inputs();
    check_output("ebubble_busy", {63'd0, mdu.busy}, 64'd0);

    // start and mthi together: move dropped
    mdu.op   = OP_MULTU;
    mdu.ea   = 32'hCAFE0000;
    mdu.eb   = 32'd2;
    mdu.mthi = 1'b1;
    mdu.start = 1'b1;
    step();
    begin
      exp_t e;
      e     = ref_model(OP_MULTU, 32'hCAFE0000, 32'd2);
      e.due = cyc + 33;
      scoreboard.push_back(e);
    end
    clear_inputs();
    check_output("start_wins_hi", {32'd0, mdu.hi}, {32'd0, model_hi});

    // reset mid-operation
    wait_idle();
    mdu.op = OP_MULT;
    mdu.ea = 32'h00012345;
    mdu.eb = 32'h00006789;
    mdu.start = 1'b1;
    step();
    mdu.start = 1'b0;
    repeat (19) step();
    reset = 1'b1;
    step();
    check_output("midreset_busy", {63'd0, mdu.busy}, 64'd0);
    check_output("midreset_done", {63'd0, mdu.done}, 64'd0);
    check_output("midreset_hi", {32'd0, mdu.hi}, 64'd0);
    check_output("midreset_lo", {32'd0, mdu.lo}, 64'd0);
    reset    = 1'b0;
    model_hi = '0;
    model_lo = '0;
    apply_stimulus(OP_MULT, 32'hFFFF0001, 32'h00001234);

    // randomized operations with occasional moves
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel == 1) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end else if (sel == 2) begin
        a = a % 1000;
        b = b % 50;
      end else if (sel == 3) b = b % 16;
      apply_stimulus(op, a, b);
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        a = $urandom;
        mdu.ea = a;
        if ($urandom_range(0, 1) == 0) begin
          mdu.mthi = 1'b1;
          step();
          mdu.mthi = 1'b0;
          check_output("rand_mthi", {32'd0, mdu.hi}, {32'd0, a});
          model_hi = a;
        end else begin
          mdu.mtlo = 1'b1;
          step();
          mdu.mtlo = 1'b0;
          check_output("rand_mtlo", {32'd0, mdu.lo}, {32'd0, a});
          model_lo = a;
        end
      end
    end

    wait_idle();
    step();
    check_output("scoreboard_empty", 64'(scoreboard.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
